// File: rtl/aes_key_pkg.sv
// Shared widths, key-length encodings, round-count lookup and read-FSM states
// for the round-key store.
package aes_key_pkg;

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned RK_DEPTH = 15;
  localparam int unsigned AW       = 4;

  typedef enum logic [1:0] {
    KL_NONE = 2'b00,
    KL_128  = 2'b01,
    KL_192  = 2'b10,
    KL_256  = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rd_state_e;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (key_len_e'(kl))
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/round_key_ram.sv
// Round-key storage array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner tracks which entries hold live data.
module round_key_ram #(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/round_key_store.sv
// Round-key register file with per-entry valid bits and a stalling read port.
// Optional macro RKS_BYPASS_EN forwards a same-cycle write to a pending/new read.
module round_key_store #(
  parameter int unsigned KEY_W = aes_key_pkg::KEY_W,
  parameter int unsigned DEPTH = aes_key_pkg::RK_DEPTH,
  parameter int unsigned AW    = aes_key_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_valid,
  input  logic [1:0]       key_len,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ready,
  output logic             rd_ack,
  output logic [KEY_W-1:0] rd_data,
  output logic             rd_oob,
  output logic [3:0]       num_rounds,
  output logic             keys_ready,
  output logic             wr_err
);

  import aes_key_pkg::*;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  rd_state_e        state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [1:0]       key_len_q, key_len_d;
  logic [3:0]       num_rounds_q, num_rounds_d;
  logic             keys_ready_q, keys_ready_d;
  logic             wr_err_q, wr_err_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [KEY_W-1:0] rd_data_q, rd_data_d;
  logic             rd_oob_q, rd_oob_d;

  logic             wr_in_range;
  logic             rd_in_range;
  logic [AW-1:0]    req_addr;
  logic             fwd_hit;
  logic [KEY_W-1:0] ram_rd_data;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  // While stalled the RAM read port follows the latched address, otherwise the request.
  assign req_addr    = (state_q == ST_WAIT) ? addr_q : rd_addr;

`ifdef RKS_BYPASS_EN
  assign fwd_hit = wr_valid && (wr_addr == req_addr);
`else
  assign fwd_hit = 1'b0;
`endif

  round_key_ram #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_valid && wr_in_range),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (req_addr),
    .rd_data (ram_rd_data)
  );

  // Clear takes effect before a same-cycle write, so that write survives.
  always_comb begin
    valid_d   = valid_q;
    key_len_d = key_len_q;
    wr_err_d  = wr_err_q;
    if (clear_valid) begin
      valid_d   = '0;
      key_len_d = key_len;
      wr_err_d  = 1'b0;
    end
    if (wr_valid) begin
      if (wr_in_range) begin
        valid_d[wr_addr] = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end
    num_rounds_d = nr_of(key_len_d);
    keys_ready_d = (num_rounds_d != 4'd0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((i <= 32'(num_rounds_d)) && !valid_d[AW'(i)]) begin
        keys_ready_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    rd_oob_d  = rd_oob_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (rd_req) begin
          addr_d = rd_addr;
          if (!rd_in_range) begin
            state_d   = ST_RESP;
            rd_oob_d  = 1'b1;
            rd_data_d = '0;
          end else if (fwd_hit) begin
            state_d   = ST_RESP;
            rd_oob_d  = 1'b0;
            rd_data_d = wr_data;
          end else if (valid_q[rd_addr]) begin
            state_d   = ST_RESP;
            rd_oob_d  = 1'b0;
            rd_data_d = ram_rd_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (fwd_hit) begin
          state_d   = ST_RESP;
          rd_oob_d  = 1'b0;
          rd_data_d = wr_data;
        end else if (valid_q[addr_q]) begin
          state_d   = ST_RESP;
          rd_oob_d  = 1'b0;
          rd_data_d = ram_rd_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      key_len_q    <= 2'b00;
      num_rounds_q <= 4'd0;
      keys_ready_q <= 1'b0;
      wr_err_q     <= 1'b0;
      addr_q       <= '0;
      rd_data_q    <= '0;
      rd_oob_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      key_len_q    <= key_len_d;
      num_rounds_q <= num_rounds_d;
      keys_ready_q <= keys_ready_d;
      wr_err_q     <= wr_err_d;
      addr_q       <= addr_d;
      rd_data_q    <= rd_data_d;
      rd_oob_q     <= rd_oob_d;
    end
  end

  assign rd_ready   = (state_q != ST_WAIT);
  assign rd_ack     = (state_q == ST_RESP);
  assign rd_data    = rd_data_q;
  assign rd_oob     = rd_oob_q;
  assign num_rounds = num_rounds_q;
  assign keys_ready = keys_ready_q;
  assign wr_err     = wr_err_q;

endmodule
